// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the memory arbiter.
// Debug FSM states, read-data owners, grant codes and the RAM request bundle.
package mem_arbiter_pkg;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 7;
    localparam int unsigned WAIT_CNT_W = 3;

    typedef enum logic [1:0] {
        DBG_IDLE = 2'd0,
        DBG_WAIT = 2'd1,
        DBG_RESP = 2'd2
    } dbg_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ST   = 2'd1,
        GNT_LD   = 2'd2,
        GNT_DBG  = 2'd3
    } grant_t;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } ram_req_t;

    // Saturating increment of the debug wait counter.
    function automatic logic [WAIT_CNT_W-1:0] sat_inc(
        input logic [WAIT_CNT_W-1:0] v,
        input logic [WAIT_CNT_W-1:0] lim
    );
        return (v >= lim) ? lim : v + 3'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between CPU store, CPU load and a debug port.
// Fixed priority store > load > debug, with a starvation override for debug.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_ren,
    input  logic [31:0] ld_addr,
    input  logic        st_wen,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_wmask,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wmask,
    input  logic [31:0] ram_rdata,
    output logic        stall_id,
    output logic        stall_all
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(STARVE_LIMIT);

    dbg_state_t            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    owner_t                owner_q, owner_d;
    grant_t                gnt;
    ram_req_t              req;
    logic                  cpu_req;
    logic                  override;

    // Pick one requester per cycle; a starved debug request beats the CPU.
    always_comb begin
        cpu_req  = st_wen | ld_ren;
        override = !rst && (state_q == DBG_WAIT) && dbg_req
                   && (cnt_q == LIMIT);
        gnt      = GNT_NONE;
        if (rst) begin
            gnt = GNT_NONE;
        end else if (override) begin
            gnt = GNT_DBG;
        end else if (st_wen) begin
            gnt = GNT_ST;
        end else if (ld_ren) begin
            gnt = GNT_LD;
        end else if (dbg_req && (state_q != DBG_RESP)) begin
            gnt = GNT_DBG;
        end
    end

    // Steer the granted requester onto the RAM port; idle port is all zero.
    always_comb begin
        req = '0;
        unique case (gnt)
            GNT_ST: begin
                req.en    = 1'b1;
                req.we    = 1'b1;
                req.addr  = st_addr;
                req.wdata = st_wdata;
                req.wmask = st_wmask;
            end
            GNT_LD: begin
                req.en   = 1'b1;
                req.addr = ld_addr;
            end
            GNT_DBG: begin
                req.en    = 1'b1;
                req.we    = dbg_we;
                req.addr  = dbg_addr;
                req.wdata = dbg_we ? dbg_wdata : 32'd0;
                req.wmask = dbg_we ? 4'hF : 4'h0;
            end
            default: req = '0;
        endcase
    end

    assign ram_en    = req.en;
    assign ram_we    = req.we;
    assign ram_addr  = req.addr;
    assign ram_wdata = req.wdata;
    assign ram_wmask = req.wmask;

    // Stalls: a stolen cycle freezes everything, a store/load clash only ID.
    always_comb begin
        stall_all = override;
        stall_id  = !rst && !override && st_wen && ld_ren;
    end

    // Debug FSM next state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            DBG_IDLE: begin
                if (dbg_req) begin
                    if (cpu_req) begin
                        state_d = DBG_WAIT;
                        cnt_d   = WAIT_CNT_W'(1);
                    end else begin
                        state_d = DBG_RESP;
                        cnt_d   = '0;
                    end
                end
            end
            DBG_WAIT: begin
                if (gnt == GNT_DBG) begin
                    state_d = DBG_RESP;
                    cnt_d   = '0;
                end else if (!dbg_req) begin
                    // A withdrawn request is abandoned rather than issued blind.
                    state_d = DBG_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q, LIMIT);
                end
            end
            DBG_RESP: begin
                state_d = DBG_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = DBG_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Who receives the read data that comes back next cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (gnt == GNT_LD) begin
            owner_d = OWN_CPU;
        end else if ((gnt == GNT_DBG) && !dbg_we) begin
            owner_d = OWN_DBG;
        end
    end

    // State, counter and owner registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DBG_IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    // Return path: RAM data goes only to the registered owner.
    always_comb begin
        ld_valid  = 1'b0;
        ld_rdata  = 32'd0;
        dbg_ack   = 1'b0;
        dbg_rdata = 32'd0;
        if (!rst) begin
            ld_valid = (owner_q == OWN_CPU);
            dbg_ack  = (state_q == DBG_RESP);
            if (owner_q == OWN_CPU) begin
                ld_rdata = ram_rdata;
            end
            if (dbg_ack && (owner_q == OWN_DBG)) begin
                dbg_rdata = ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle RAM and a behavioural model.
// Every cycle is checked against the model; literals pin key results.
module tb_mem_arbiter;

    localparam int STARVE = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_ren;
    logic [31:0] ld_addr;
    logic        st_wen;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_wmask;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        ld_valid;
    logic [31:0] ld_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wmask;
    logic [31:0] ram_rdata;
    logic        stall_id;
    logic        stall_all;

    int n_vec = 0;
    int n_bad = 0;

    mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .ld_ren(ld_ren), .ld_addr(ld_addr),
        .st_wen(st_wen), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_wmask(st_wmask),
        .dbg_req(dbg_req), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ld_valid(ld_valid), .ld_rdata(ld_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
        .ram_rdata(ram_rdata),
        .stall_id(stall_id), .stall_all(stall_all)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(
        input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // RAM: synchronous, one-cycle read latency, byte-masked writes.
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            ram[ram_addr[11:2]] <= merge(ram[ram_addr[11:2]], ram_wdata, ram_wmask);
        end
        if (ram_en && !ram_we) begin
            ram_rdata <= ram[ram_addr[11:2]];
        end
    end

    // Model state: memory image, debug wait bookkeeping, pending return.
    logic [31:0] mmem [0:1023];
    bit          m_waiting;
    int          m_waits;
    bit          m_ack_due;
    int          m_ret_own;
    logic [31:0] m_ret_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare all outputs with the model, then advance the model one cycle.
    task automatic model_cycle();
        logic        e_en, e_we, e_lv, e_ack, e_sid, e_sall;
        logic [31:0] e_addr, e_wdata, e_ld, e_dbg;
        logic [3:0]  e_mask;
        int          g;
        bit          starving;
        e_en = 0; e_we = 0; e_lv = 0; e_ack = 0; e_sid = 0; e_sall = 0;
        e_addr = 0; e_wdata = 0; e_ld = 0; e_dbg = 0; e_mask = 0;
        g = 0;
        starving = 0;
        if (!rst) begin
            starving = m_waiting && dbg_req && (m_waits >= STARVE);
            if (starving) g = 3;
            else if (st_wen) g = 1;
            else if (ld_ren) g = 2;
            else if (dbg_req && !m_ack_due) g = 3;
            if (g == 1) begin
                e_en = 1; e_we = 1; e_addr = st_addr;
                e_wdata = st_wdata; e_mask = st_wmask;
            end else if (g == 2) begin
                e_en = 1; e_addr = ld_addr;
            end else if (g == 3) begin
                e_en = 1; e_we = dbg_we; e_addr = dbg_addr;
                e_wdata = dbg_we ? dbg_wdata : 32'd0;
                e_mask = dbg_we ? 4'hF : 4'h0;
            end
            e_sid  = st_wen && ld_ren && !starving;
            e_sall = starving;
            e_lv   = (m_ret_own == 1);
            e_ld   = e_lv ? m_ret_data : 32'd0;
            e_ack  = m_ack_due;
            e_dbg  = (m_ret_own == 2) ? m_ret_data : 32'd0;
        end
        chk1("ram_en", ram_en, e_en);
        chk1("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_wdata", ram_wdata, e_wdata);
        chk("ram_wmask", 32'(ram_wmask), 32'(e_mask));
        chk1("ld_valid", ld_valid, e_lv);
        chk("ld_rdata", ld_rdata, e_ld);
        chk1("dbg_ack", dbg_ack, e_ack);
        chk("dbg_rdata", dbg_rdata, e_dbg);
        chk1("stall_id", stall_id, e_sid);
        chk1("stall_all", stall_all, e_sall);
        if (rst) begin
            m_waiting = 0; m_waits = 0; m_ack_due = 0;
            m_ret_own = 0; m_ret_data = 0;
        end else begin
            m_ret_own = 0;
            m_ret_data = 0;
            if (g == 2) begin
                m_ret_own = 1; m_ret_data = mmem[ld_addr[11:2]];
            end
            if (g == 3 && !dbg_we) begin
                m_ret_own = 2; m_ret_data = mmem[dbg_addr[11:2]];
            end
            if (g == 1) mmem[st_addr[11:2]] = merge(mmem[st_addr[11:2]], st_wdata, st_wmask);
            if (g == 3 && dbg_we) mmem[dbg_addr[11:2]] = dbg_wdata;
            if (g == 3) begin
                m_waiting = 0; m_waits = 0;
            end else if (dbg_req && !m_ack_due) begin
                m_waiting = 1;
                if (m_waits < STARVE) m_waits++;
            end else if (!dbg_req) begin
                m_waiting = 0; m_waits = 0;
            end
            m_ack_due = (g == 3);
        end
    endtask

    task automatic clr();
        rst = 0; ld_ren = 0; ld_addr = 0; st_wen = 0; st_addr = 0;
        st_wdata = 0; st_wmask = 0; dbg_req = 0; dbg_we = 0;
        dbg_addr = 0; dbg_wdata = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mmem[i] = 32'd0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
        m_waiting = 0; m_waits = 0; m_ack_due = 0;
        m_ret_own = 0; m_ret_data = 0;
        clr();
        rst = 1;
        @(posedge clk);
        #1;
        // Reset with requests present: everything must stay zero.
        rst = 1; st_wen = 1; st_addr = 32'h40; st_wdata = 32'h1; st_wmask = 4'hF;
        dbg_req = 1; ld_ren = 1;
        cyc();
        chk1("rst_ram_en", ram_en, 1'b0);
        chk1("rst_stall_id", stall_id, 1'b0);
        nxt();
        rst = 1;
        cyc(); nxt();
        // Seed 0x100 with DEADBEEF through the store port.
        st_wen = 1; st_addr = 32'h100; st_wdata = 32'hDEADBEEF; st_wmask = 4'hF;
        cyc();
        chk1("seed_we", ram_we, 1'b1);
        nxt();
        // Lone load.
        ld_ren = 1; ld_addr = 32'h100;
        cyc();
        chk1("lone_sid", stall_id, 1'b0);
        nxt();
        cyc();
        chk1("lone_valid", ld_valid, 1'b1);
        chk("lone_rdata", ld_rdata, 32'hDEADBEEF);
        nxt();
        // Store/load conflict.
        st_wen = 1; st_addr = 32'h200; st_wdata = 32'h12345678; st_wmask = 4'hF;
        ld_ren = 1; ld_addr = 32'h100;
        cyc();
        chk("conf_addr0", ram_addr, 32'h200);
        chk1("conf_sid0", stall_id, 1'b1);
        nxt();
        ld_ren = 1; ld_addr = 32'h100;
        cyc();
        chk("conf_addr1", ram_addr, 32'h100);
        chk1("conf_we1", ram_we, 1'b0);
        nxt();
        cyc();
        chk("conf_rdata2", ld_rdata, 32'hDEADBEEF);
        nxt();
        // Partial-mask store then read back.
        st_wen = 1; st_addr = 32'h200; st_wdata = 32'hFFFFFFFF; st_wmask = 4'b0011;
        cyc(); nxt();
        ld_ren = 1; ld_addr = 32'h200;
        cyc(); nxt();
        cyc();
        chk("mask_rdata", ld_rdata, 32'h1234FFFF);
        nxt();
        // Debug write while idle.
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h300; dbg_wdata = 32'hA5A5A5A5;
        cyc();
        chk1("dbgw_we", ram_we, 1'b1);
        chk("dbgw_wdata", ram_wdata, 32'hA5A5A5A5);
        chk1("dbgw_ack0", dbg_ack, 1'b0);
        nxt();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h300; dbg_wdata = 32'hA5A5A5A5;
        cyc();
        chk1("dbgw_ack1", dbg_ack, 1'b1);
        chk1("dbgw_resp_en", ram_en, 1'b0);
        nxt();
        ld_ren = 1; ld_addr = 32'h300;
        cyc(); nxt();
        cyc();
        chk("dbgw_readback", ld_rdata, 32'hA5A5A5A5);
        nxt();
        // Starvation: debug read of 0x100 behind a continuous load stream.
        for (int k = 1; k <= 8; k++) begin
            ld_ren = 1; ld_addr = 32'h300;
            dbg_req = 1; dbg_addr = 32'h100;
            cyc();
            if (k == 7) chk1("starve_c7_all", stall_all, 1'b0);
            if (k == 8) begin
                chk1("starve_c8_all", stall_all, 1'b1);
                chk("starve_c8_addr", ram_addr, 32'h100);
                chk1("starve_c8_sid", stall_id, 1'b0);
            end
            nxt();
        end
        ld_ren = 1; ld_addr = 32'h300; dbg_req = 1; dbg_addr = 32'h100;
        cyc();
        chk1("starve_ack", dbg_ack, 1'b1);
        chk("starve_drdata", dbg_rdata, 32'hDEADBEEF);
        chk1("starve_noval", ld_valid, 1'b0);
        nxt();
        cyc();
        chk("starve_ld_after", ld_rdata, 32'hA5A5A5A5);
        nxt();
        // Reset during RESP of a debug read.
        dbg_req = 1; dbg_addr = 32'h200;
        cyc(); nxt();
        rst = 1; dbg_req = 1; dbg_addr = 32'h200;
        cyc();
        chk1("rresp_ack", dbg_ack, 1'b0);
        chk("rresp_rdata", dbg_rdata, 32'h0);
        nxt();
        cyc();
        chk1("rresp_after_ack", dbg_ack, 1'b0);
        chk1("rresp_after_valid", ld_valid, 1'b0);
        nxt();
        dbg_req = 1; dbg_addr = 32'h100;
        cyc();
        chk1("rresp_idle_grant", ram_en, 1'b1);
        nxt();
        dbg_req = 1; dbg_addr = 32'h100;
        cyc(); nxt();
        // Store, load and debug together, then count to the override.
        for (int k = 0; k <= 7; k++) begin
            if (k == 0) begin
                st_wen = 1; st_addr = 32'h400; st_wdata = 32'h11; st_wmask = 4'hF;
            end
            ld_ren = 1; ld_addr = 32'h100;
            dbg_req = 1; dbg_addr = 32'h300;
            cyc();
            if (k == 0) begin
                chk1("prio_we", ram_we, 1'b1);
                chk1("prio_sid", stall_id, 1'b1);
                chk1("prio_sall", stall_all, 1'b0);
            end
            if (k == 6) chk1("prio_c6_all", stall_all, 1'b0);
            if (k == 7) begin
                chk1("prio_c7_all", stall_all, 1'b1);
                chk("prio_c7_addr", ram_addr, 32'h300);
            end
            nxt();
        end
        dbg_req = 1; dbg_addr = 32'h300; ld_ren = 1; ld_addr = 32'h100;
        cyc();
        chk("prio_drdata", dbg_rdata, 32'hA5A5A5A5);
        nxt();
        cyc(); nxt();
        // Debug granted out of WAIT once the CPU goes quiet.
        ld_ren = 1; ld_addr = 32'h100;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h500; dbg_wdata = 32'h0BADF00D;
        cyc(); nxt();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h500; dbg_wdata = 32'h0BADF00D;
        cyc();
        chk("wait_grant_addr", ram_addr, 32'h500);
        chk1("wait_grant_all", stall_all, 1'b0);
        nxt();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h500; dbg_wdata = 32'h0BADF00D;
        cyc();
        chk1("wait_ack", dbg_ack, 1'b1);
        nxt();
        ld_ren = 1; ld_addr = 32'h500;
        cyc(); nxt();
        cyc();
        chk("wait_readback", ld_rdata, 32'h0BADF00D);
        nxt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 7, meaning the count of waiting cycles after which a pending debug request overrides CPU traffic (range 1..7).
REQ-002 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have load-port inputs: ld_ren (1) and ld_addr (32), driven by the decode stage's RAM read enable and address.
REQ-005 SHALL have store-port inputs: st_wen (1), st_addr (32), st_wdata (32) and st_wmask (4), driven by the execute stage.
REQ-006 SHALL have debug-port inputs dbg_req (1), dbg_we (1), dbg_addr (32) and dbg_wdata (32), and debug-port outputs dbg_ack (1) and dbg_rdata (32).
REQ-007 SHALL have outputs ld_rdata (32) and ld_valid (1), carrying load data back to the execute stage.
REQ-008 SHALL have RAM-side outputs ram_en (1), ram_we (1), ram_addr (32), ram_wdata (32) and ram_wmask (4), and RAM-side input ram_rdata (32), which has 1-cycle synchronous read latency.
REQ-009 SHALL have output stall_id (1): freeze PC and IF/ID, and inject a bubble into EX.
REQ-010 SHALL have output stall_all (1): freeze all stages and suppress register-file writeback.

Function
REQ-011 SHALL issue at most one RAM access per cycle.
REQ-012 SHALL drive the RAM outputs combinationally from the granted requester and drive all-zero RAM outputs when nothing is granted.
REQ-013 SHALL use grant priority store > load > debug, except when starvation override applies (REQ-018).
REQ-014 SHALL, when st_wen and ld_ren are both asserted without override, grant the store and assert stall_id for that cycle; the load is re-presented and granted the next cycle.
REQ-015 SHALL, for a granted load, assert ld_valid with ld_rdata = ram_rdata exactly one cycle after the grant; otherwise ld_valid = 0 and ld_rdata = 0.
REQ-016 SHALL implement a debug FSM with states IDLE, WAIT, RESP, transitioning as follows:
- IDLE to RESP when dbg_req=1 and no CPU request.
- IDLE to WAIT when dbg_req=1 and a CPU request is present.
- WAIT to RESP on grant.
- RESP to IDLE unconditionally.
REQ-017 SHALL, in WAIT, increment a 3-bit wait counter each cycle the debug request is not granted, saturating at STARVE_LIMIT; the counter clears on grant.
REQ-018 SHALL, when in WAIT with counter == STARVE_LIMIT, grant debug regardless of CPU requests and assert stall_all for that cycle; any CPU request that cycle is held and re-presented.
REQ-019 SHALL pulse dbg_ack for exactly one cycle, in RESP; on reads, dbg_rdata = ram_rdata in that cycle and 0 otherwise.
REQ-020 SHALL ignore dbg_req while in RESP; the requester holds dbg_req and its fields stable until dbg_ack and drops dbg_req the cycle after.
REQ-021 SHALL track read-data ownership in a registered owner field (NONE/CPU/DBG), so that returned data goes only to the owner.
REQ-022 SHALL keep stall_id and stall_all mutually exclusive; stall_all takes precedence.
REQ-023 SHALL issue addresses unmodified as byte addresses; word alignment is the RAM's concern.

Reset
REQ-024 SHALL, in any cycle with rst=1, force FSM = IDLE, counter = 0 and owner = NONE.
REQ-025 SHALL, in any cycle with rst=1, drive all outputs to 0 (ram_*, ld_*, dbg_*, stall_*).
REQ-026 SHALL, on reset asserted mid-transaction (WAIT or RESP), drop the pending debug request without an ack and discard any in-flight read.

Structure
REQ-027 SHALL place the FSM state encodings, the owner encodings and the default STARVE_LIMIT in the shared defines file.
REQ-028 SHALL be a single module with no sub-module; the arbiter is small enough that a separate counter block adds nothing.

Verification
REQ-029 SHALL cover a lone load: ld_ren=1, ld_addr=0x100, RAM word 0xDEADBEEF -> next cycle ld_valid=1, ld_rdata=0xDEADBEEF, no stall.
REQ-030 SHALL cover a store/load conflict: st_wen=1 (0x200, 0x12345678, mask 0xF) with ld_ren=1 (0x100) -> cycle 0 ram_we=1 at 0x200 and stall_id=1; cycle 1 read at 0x100; cycle 2 ld_valid=1.
REQ-031 SHALL cover a debug write when idle: dbg_req=1, dbg_we=1, 0x300, 0xA5A5A5A5 -> RAM write the same cycle; dbg_ack=1 the next cycle; a subsequent CPU read of 0x300 returns 0xA5A5A5A5.
REQ-032 SHALL cover starvation: continuous ld_ren=1 plus a pending debug read of 0x100 -> debug granted on the 8th cycle with stall_all=1; dbg_ack=1 the cycle after with dbg_rdata=0xDEADBEEF; ld_valid=0 for the stolen cycle.
REQ-033 SHALL cover reset mid-operation: rst=1 during RESP of a debug read -> dbg_ack=0, all outputs 0 the following cycle, FSM in IDLE.
REQ-034 SHALL cover priority: simultaneous st_wen, ld_ren and dbg_req with counter 0 -> store granted, stall_id=1, debug enters WAIT with counter 1.
